// File: rtl/phase_error_monitor.sv
// Phase-error monitor: decimates the signed PD error into a circular capture buffer
// that freezes after an over-threshold trigger, and tracks min/max error and lock.
module phase_error_monitor #(
    parameter int ERR_W      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int DECIM      = 1,
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_COUNT = 8,
    parameter int POST_TRIG  = 8
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_n_i,
    input  logic                    enable_i,
    input  logic signed [ERR_W-1:0] error_i,
    input  logic                    error_valid_i,
    input  logic                    arm_i,
    input  logic [ERR_W-1:0]        trig_thresh_i,
    input  logic                    rd_en_i,
    input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
    output logic [ERR_W-1:0]        rd_data_o,
    output logic                    rd_valid_o,
    output logic [1:0]              state_o,
    output logic [DEPTH_LOG2-1:0]   wr_ptr_o,
    output logic                    locked_o,
    output logic signed [ERR_W-1:0] err_min_o,
    output logic signed [ERR_W-1:0] err_max_o
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PCNT_W = (POST_TRIG > 1) ? $clog2(POST_TRIG) : 1;
    localparam int LCNT_W = $clog2(LOCK_COUNT + 1);

    localparam logic [DCNT_W-1:0]       DCNT_LAST = DCNT_W'(DECIM - 1);
    localparam logic [PCNT_W-1:0]       PCNT_LAST = PCNT_W'(POST_TRIG - 1);
    localparam logic [LCNT_W-1:0]       LCNT_FULL = LCNT_W'(LOCK_COUNT);
    localparam logic [ERR_W:0]          TOL_V     = (ERR_W + 1)'(LOCK_TOL);
    localparam logic signed [ERR_W-1:0] ERR_POS   = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0] ERR_NEG   = {1'b1, {(ERR_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    // One extra bit so the most negative sample has a representable magnitude.
    function automatic logic [ERR_W:0] abs_err(input logic signed [ERR_W-1:0] v);
        logic signed [ERR_W:0] w;
        w = {v[ERR_W-1], v};
        return w[ERR_W] ? $unsigned(-w) : $unsigned(w);
    endfunction

    function automatic logic [LCNT_W-1:0] lock_sat(input logic [LCNT_W-1:0] cnt,
                                                   input logic in_tol);
        if (!in_tol)
            return '0;
        else if (cnt == LCNT_FULL)
            return cnt;
        else
            return cnt + LCNT_W'(1);
    endfunction

    state_t                  state;
    logic [DCNT_W-1:0]       dcnt;
    logic [PCNT_W-1:0]       post_cnt;
    logic [LCNT_W-1:0]       lock_cnt;
    logic [LCNT_W-1:0]       lock_nxt;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic signed [ERR_W-1:0] err_min;
    logic signed [ERR_W-1:0] err_max;
    logic signed [ERR_W-1:0] min_base;
    logic signed [ERR_W-1:0] max_base;
    logic signed [ERR_W-1:0] min_nxt;
    logic signed [ERR_W-1:0] max_nxt;
    logic [ERR_W:0]          mag;
    logic                    accept;
    logic                    arm_take;
    logic                    wr;
    logic                    over;
    logic                    in_tol;
    logic [ERR_W-1:0]        mem [DEPTH];

    always_comb begin
        accept   = enable_i && error_valid_i && (dcnt == DCNT_LAST);
        arm_take = enable_i && arm_i && ((state == IDLE) || (state == FROZEN));
        wr       = accept && (state != FROZEN);
        mag      = abs_err(error_i);
        over     = mag > {1'b0, trig_thresh_i};
        in_tol   = mag <= TOL_V;
        lock_nxt = lock_sat(lock_cnt, in_tol);
        // Arming clears min/max first; a coincident sample then folds in.
        min_base = arm_take ? ERR_POS : err_min;
        max_base = arm_take ? ERR_NEG : err_max;
        min_nxt  = (accept && (error_i < min_base)) ? error_i : min_base;
        max_nxt  = (accept && (error_i > max_base)) ? error_i : max_base;
    end

    always_ff @(posedge fpga_clk_i) begin
        if (wr)
            mem[wr_ptr] <= error_i;
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i)
                rd_data_o <= mem[rd_addr_i];
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            dcnt     <= '0;
            post_cnt <= '0;
            lock_cnt <= '0;
            locked_o <= 1'b0;
            wr_ptr   <= '0;
            err_min  <= ERR_POS;
            err_max  <= ERR_NEG;
        end else if (enable_i) begin
            if (error_valid_i)
                dcnt <= accept ? '0 : dcnt + DCNT_W'(1);
            if (wr)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            err_min <= min_nxt;
            err_max <= max_nxt;
            if (accept) begin
                lock_cnt <= lock_nxt;
                locked_o <= (lock_nxt == LCNT_FULL);
            end
            case (state)
                IDLE: begin
                    if (arm_take)
                        state <= ARMED;
                end
                ARMED: begin
                    if (accept && over) begin
                        post_cnt <= '0;
                        state    <= (POST_TRIG == 0) ? FROZEN : POST;
                    end
                end
                POST: begin
                    if (accept) begin
                        if (post_cnt == PCNT_LAST)
                            state <= FROZEN;
                        else
                            post_cnt <= post_cnt + PCNT_W'(1);
                    end
                end
                FROZEN: begin
                    if (arm_take)
                        state <= ARMED;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o   = state;
    assign wr_ptr_o  = wr_ptr;
    assign err_min_o = err_min;
    assign err_max_o = err_max;

endmodule

// File: tb/tb_phase_error_monitor.sv
// Directed bench for phase_error_monitor: default instance plus a DECIM=4 instance
// sharing stimulus; buffer reads are checked through an expected-value queue.
module tb_phase_error_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] err = '0;
    logic       vld = 1'b0;
    logic       arm = 1'b0;
    logic [7:0] thresh = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;

    logic [7:0] rd_data, d_rd_data;
    logic       rd_valid, d_rd_valid;
    logic [1:0] state, d_state;
    logic [3:0] wr_ptr, d_wr_ptr;
    logic       locked, d_locked;
    logic [7:0] emin, emax, d_emin, d_emax;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    phase_error_monitor u_dut (
        .fpga_clk_i(clk), .reset_n_i(rst_n), .enable_i(en), .error_i(err),
        .error_valid_i(vld), .arm_i(arm), .trig_thresh_i(thresh),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_valid_o(rd_valid), .state_o(state), .wr_ptr_o(wr_ptr),
        .locked_o(locked), .err_min_o(emin), .err_max_o(emax)
    );

    phase_error_monitor #(.DECIM(4)) u_dec (
        .fpga_clk_i(clk), .reset_n_i(rst_n), .enable_i(en), .error_i(err),
        .error_valid_i(vld), .arm_i(arm), .trig_thresh_i(thresh),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(d_rd_data),
        .rd_valid_o(d_rd_valid), .state_o(d_state), .wr_ptr_o(d_wr_ptr),
        .locked_o(d_locked), .err_min_o(d_emin), .err_max_o(d_emax)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input bit dec);
        logic [7:0] expv;
        chk("rd_valid", dec ? d_rd_valid : rd_valid, 1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            expv = exp_q.pop_front();
            chk("rd_data", dec ? d_rd_data : rd_data, expv);
        end
    endtask

    // Back-to-back reads of n consecutive addresses; expectations already queued.
    task automatic read_seq(input bit dec, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) pop_chk(dec);
            rd_en = 1'b1;
            rd_addr = 4'(first + i);
        end
        @(negedge clk);
        rd_en = 1'b0;
        pop_chk(dec);
    endtask

    task automatic strobe(input logic [7:0] e);
        @(negedge clk);
        err = e;
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_wr_ptr"}, wr_ptr, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_min"}, emin, 8'h7f);
        chk({tag, "_max"}, emax, 8'h80);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // Rolling capture: 0..19 into a 16-deep buffer
        for (int i = 0; i < 20; i++) strobe(8'(i));
        chk("roll_wr_ptr", wr_ptr, 4);
        chk("roll_state", state, 0);
        chk("roll_min", emin, 0);
        chk("roll_max", emax, 19);
        chk("roll_locked", locked, 0);
        for (int a = 0; a < 16; a++) exp_q.push_back(8'(a < 4 ? a + 16 : a));
        read_seq(1'b0, 0, 16);

        // Lock: 8 in-tolerance samples, one outlier, then 7 and 1 more
        strobe(8'(-2)); strobe(8'(2)); strobe(8'(-1)); strobe(8'(1));
        strobe(8'(0)); strobe(8'(-2)); strobe(8'(2));
        chk("lock_after7", locked, 0);
        strobe(8'(-1));
        chk("lock_after8", locked, 1);
        strobe(8'(3));
        chk("lock_outlier", locked, 0);
        for (int i = 0; i < 7; i++) strobe(8'(0));
        chk("lock_relock7", locked, 0);
        strobe(8'(0));
        chk("lock_relock8", locked, 1);

        // Trigger and freeze (37 samples so far -> wr_ptr 5)
        thresh = 8'd10;
        arm_pulse();
        chk("arm_state", state, 1);
        chk("arm_min", emin, 8'h7f);
        chk("arm_max", emax, 8'h80);
        chk("arm_wr_ptr", wr_ptr, 5);
        strobe(8'd10);
        chk("thresh_equal_no_trig", state, 1);
        strobe(8'd0); strobe(8'd0);
        strobe(8'd11);
        chk("trig_state", state, 2);
        chk("trig_wr_ptr", wr_ptr, 9);
        for (int i = 0; i < 7; i++) strobe(8'd1);
        chk("post7_state", state, 2);
        strobe(8'd1);
        chk("post8_state", state, 3);
        chk("frozen_wr_ptr", wr_ptr, 1);
        for (int i = 0; i < 3; i++) strobe(8'd5);
        chk("frozen_hold_ptr", wr_ptr, 1);
        chk("frozen_hold_state", state, 3);
        chk("frozen_min", emin, 0);
        chk("frozen_max", emax, 11);
        exp_q.push_back(8'd11);
        read_seq(1'b0, 8, 1);
        exp_q.push_back(8'd1);
        read_seq(1'b0, 0, 1);

        // Arm coinciding with an accepted sample while frozen
        @(negedge clk);
        arm = 1'b1; vld = 1'b1; err = 8'd50;
        @(negedge clk);
        arm = 1'b0; vld = 1'b0;
        chk("coll_state", state, 1);
        chk("coll_wr_ptr", wr_ptr, 1);
        chk("coll_min", emin, 8'd50);
        chk("coll_max", emax, 8'd50);
        exp_q.push_back(8'd0);
        read_seq(1'b0, 1, 1);

        // Most negative sample against the largest threshold
        thresh = 8'd127;
        strobe(8'h80);
        chk("neg_trig_state", state, 2);
        chk("neg_trig_ptr", wr_ptr, 2);
        chk("neg_min", emin, 8'h80);
        chk("neg_max", emax, 8'd50);
        exp_q.push_back(8'd11);
        read_seq(1'b0, 8, 1);

        // Asynchronous reset mid-POST, between clock edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Decimation by 4 with enable dropped for two strobes mid-stream
        for (int i = 1; i <= 5; i++) strobe(8'(i));
        en = 1'b0;
        strobe(8'd99); strobe(8'd99);
        chk("en_low_main_ptr", wr_ptr, 5);
        chk("en_low_dec_ptr", d_wr_ptr, 1);
        en = 1'b1;
        for (int i = 6; i <= 12; i++) strobe(8'(i));
        chk("dec_wr_ptr", d_wr_ptr, 3);
        chk("dec_state", d_state, 0);
        chk("dec_min", d_emin, 8'd4);
        chk("dec_max", d_emax, 8'd12);
        chk("dec_main_ptr", wr_ptr, 12);
        exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd12);
        read_seq(1'b1, 0, 3);

        // Fill after a fresh reset, then read latency and same-cycle collision
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) strobe(8'(100 + i));
        chk("fill_wr_ptr", wr_ptr, 0);
        exp_q.push_back(8'd100);
        @(negedge clk);
        err = 8'd77; vld = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        @(negedge clk);
        vld = 1'b0; rd_en = 1'b0;
        pop_chk(1'b0);
        exp_q.push_back(8'd77);
        read_seq(1'b0, 0, 1);

        @(negedge clk);
        rd_en = 1'b1; rd_addr = 4'd3;
        #1 chk("lat_before_edge", rd_valid, 0);
        @(negedge clk);
        rd_en = 1'b0;
        exp_q.push_back(8'd103);
        pop_chk(1'b0);
        @(negedge clk);
        chk("lat_valid_one_cycle", rd_valid, 0);
        chk("lat_data_hold", rd_data, 8'd103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/phase_error_monitor.md
# phase_error_monitor

Parametrised on-chip successor to the simulation-only phase-error logger. It sits beside the ADPLL on `fpga_clk_i` and decimates the signed phase-detector error stream into a circular capture buffer. The buffer freezes a configurable number of samples after an over-threshold trigger. The block also tracks min/max error and asserts a lock indicator, so error history can be read out in hardware instead of through `$fwrite`.

## Interface
Parameters:
- `ERR_W`, 8: width of signed error samples (≥2).
- `DEPTH_LOG2`, 4: buffer depth is 2^DEPTH_LOG2 samples.
- `DECIM`, 1: accept every DECIM-th valid strobe (≥1).
- `LOCK_TOL`, 2: lock tolerance on |error|; unsigned.
- `LOCK_COUNT`, 8: consecutive in-tolerance samples needed to assert lock (≥1).
- `POST_TRIG`, 8: samples captured after the trigger sample; must be < 2^DEPTH_LOG2.

Ports:
- `fpga_clk_i`, in, 1: single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: when low, strobes are ignored and all state holds.
- `error_i`, in, ERR_W: signed phase error.
- `error_valid_i`, in, 1: one-cycle strobe, once per reference period.
- `arm_i`, in, 1: one-cycle pulse that arms the trigger.
- `trig_thresh_i`, in, ERR_W: unsigned trigger threshold on |error|.
- `rd_en_i`, in, 1: read request.
- `rd_addr_i`, in, DEPTH_LOG2: buffer read address.
- `rd_data_o`, out, ERR_W: read data.
- `rd_valid_o`, out, 1: read data valid.
- `state_o`, out, 2: 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN.
- `wr_ptr_o`, out, DEPTH_LOG2: next write address. After freeze, this is the oldest sample.
- `locked_o`, out, 1: lock indicator.
- `err_min_o`, out, ERR_W: signed minimum since the last arm.
- `err_max_o`, out, ERR_W: signed maximum since the last arm.

## Operation
- **Accepted sample.** A sample is accepted when `enable_i` and `error_valid_i` are high and the decimation counter equals DECIM-1.
  - The counter runs 0..DECIM-1 and advances only on valid strobes while enabled.
  - It wraps to 0 on an accepted sample.
- **Write.** An accepted sample is written to `buf[wr_ptr]` in states IDLE, ARMED and POST.
  - `wr_ptr` then increments modulo 2^DEPTH_LOG2 and wraps silently.
  - No writes occur in FROZEN.
- **Absolute value.** |error| is computed in ERR_W+1 bits, so the most negative value maps to 2^(ERR_W-1) with no overflow.
- **State machine.**
  - IDLE: rolling capture. `arm_i` moves to ARMED.
  - ARMED: rolling capture. An accepted sample with |error| > `trig_thresh_i` (strict) is written and moves to POST, with the post counter set to 0.
  - POST: each accepted sample increments the post counter. After POST_TRIG samples the state moves to FROZEN. With POST_TRIG=0, the trigger goes directly to FROZEN.
  - FROZEN: hold. `arm_i` moves to ARMED.
  - `arm_i` is ignored in ARMED and POST.
- **Arm side effects.** Taking `arm_i` resets min/max to their reset values. It does not reset `wr_ptr`.
- **Arm cycle.** If an accepted sample coincides with `arm_i` in IDLE or FROZEN:
  - in IDLE it is written; in FROZEN it is not;
  - it is never trigger-checked;
  - it does update min/max (after the clear).
- **Min/max.** Every accepted sample in every state updates them with signed compares.
- **Lock.**
  - A saturating counter 0..LOCK_COUNT increments on each accepted sample with |error| ≤ LOCK_TOL.
  - It clears to 0 on an accepted sample outside tolerance.
  - `locked_o` = (counter == LOCK_COUNT).
  - Lock tracking runs in every state, including FROZEN.
- **Read port.** It is independent of state. A read of an address written in the same cycle returns the old data.
- **Reset.** Asserting `reset_n_i` mid-operation immediately clears all state. Buffer contents are don't-care after reset.

## Timing
- Every output is registered.
- Reset values:
  - `rd_data_o` = 0, `rd_valid_o` = 0
  - `state_o` = 0 (IDLE), `wr_ptr_o` = 0
  - `locked_o` = 0
  - `err_min_o` = 2^(ERR_W-1)-1, `err_max_o` = -2^(ERR_W-1)
- A sample accepted at edge N is stored at edge N. At edge N the block also updates `wr_ptr_o`, min/max, `state_o` and `locked_o`, all visible after edge N.
- Read latency is 1 cycle: `rd_en_i` at edge N gives `rd_data_o` and `rd_valid_o` after edge N. `rd_valid_o` is high for exactly one cycle per request. `rd_data_o` holds between reads.
- Back-to-back reads give one result per cycle.
- `enable_i` low freezes the decimation, post and lock counters, the state and `wr_ptr`. Reads still work.

## Test plan
- **Rolling capture.** Defaults; 20 strobes with error = 0..19 -> `wr_ptr_o` = 4; `buf[4..15]` = 4..15 and `buf[0..3]` = 16..19; state stays IDLE; min 0, max 19.
- **Trigger and freeze.** Thresh = 10, POST_TRIG = 8; arm; errors 0,0,0,11, then ones -> state POST one cycle after the 11, FROZEN after 8 more samples; further strobes do not move `wr_ptr_o`. Edge cases: an error of exactly 10 does not trigger; error = -128 with thresh = 127 does trigger.
- **Lock.** LOCK_COUNT = 8; errors -2,2,-1,… for 8 samples -> `locked_o` rises after the 8th; one error of 3 -> `locked_o` falls after that sample; 7 good samples -> still 0.
- **Decimation.** DECIM = 4; 12 strobes with errors 1..12 -> only 4, 8, 12 are stored; `enable_i` low for 2 strobes mid-stream -> decimation phase is preserved.
- **Arm/sample collision and re-arm.** `arm_i` together with an accepted sample of error 50 while in FROZEN (thresh 10) -> state ARMED; that sample is not written and does not trigger; min = max = 50.
- **Async reset and read latency.** Assert `reset_n_i` mid-POST, asynchronously to the clock edge -> all outputs are at reset values before the next edge. Read `rd_addr_i` = 3 -> data valid exactly 1 cycle later. A read of the address being written in that cycle returns the old value.
